// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared types, constants and parameter validation for dp_ram_param
package dp_ram_pkg;

    typedef enum logic {CLEAR, RUN} state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic bit params_ok(input int data_w, input int rd_lat);
        return (data_w % 8 == 0) && (rd_lat == 1 || rd_lat == 2);
    endfunction

endpackage

// File: rtl/dp_ram_init_seq.sv
// dp_ram_init_seq: walks every word once after reset, then hands the array to the user ports
module dp_ram_init_seq
    import dp_ram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        if (state == CLEAR) begin
            state_nxt   = (clr_ptr == LAST) ? RUN : CLEAR;
            clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_ptr;
    assign busy     = (state == CLEAR);

endmodule

// File: rtl/dp_ram_param.sv
// dp_ram_param: parametrised 1W/1R RAM with byte enables, selectable read-during-write,
// optional output register and a post-reset clear sequencer
module dp_ram_param
    import dp_ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                RD_LAT   = 1,
    parameter int                RDW_MODE = RDW_OLD,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enb,
    input  logic                wr,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [ADDR_W-1:0]   r_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_be,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    output logic                busy,
    output logic                addr_err
);

    localparam int              NB      = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (!params_ok(DATA_W, RD_LAT)) begin : g_bad_params
        $error("dp_ram_param: DATA_W must be a multiple of 8 and RD_LAT 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept, wa_ok, ra_ok, wr_ok, rd_req, err;
    logic [DATA_W-1:0] rd_word, rd_val, s1_data;
    logic              s1_valid;

    dp_ram_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    assign accept = enb && !busy;
    assign wa_ok  = {1'b0, w_addr} < DEPTH_V;
    assign ra_ok  = {1'b0, r_addr} < DEPTH_V;
    assign wr_ok  = accept && wr && wa_ok;
    assign rd_req = accept && rd;
    assign err    = accept && ((wr && !wa_ok) || (rd && !ra_ok));

    // Clear sequencer owns the write port until it finishes
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= INIT_VAL;
        else if (wr_ok)
            for (int b = 0; b < NB; b++)
                if (w_be[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
    end

    always_comb begin
        rd_word = mem[r_addr];
        if (RDW_MODE == RDW_NEW && wr_ok && w_addr == r_addr)
            for (int b = 0; b < NB; b++)
                if (w_be[b]) rd_word[8*b +: 8] = w_data[8*b +: 8];
    end

    assign rd_val = ra_ok ? rd_word : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            s1_valid <= rd_req;
            addr_err <= err;
            if (rd_req) s1_data <= rd_val;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data;
        logic              s2_valid;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end
        assign r_data  = s2_data;
        assign r_valid = s2_valid;
    end else begin : g_lat1
        assign r_data  = s1_data;
        assign r_valid = s1_valid;
    end

endmodule

// File: tb/tb_dp_ram_param.sv
// tb_dp_ram_param: two configurations (RD_LAT 1/old-data, RD_LAT 2/new-data) driven in
// lockstep against an array-and-schedule reference model
module tb_dp_ram_param;

    localparam int          DEPTH = 12;
    localparam int          LAT   [2] = '{1, 2};
    localparam int          RDW   [2] = '{0, 1};
    localparam logic [31:0] INITV [2] = '{32'h0, 32'hDEAD_BEEF};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enb = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [3:0]  wa = '0, ra = '0, be = '0;
    logic [31:0] wd = '0;

    logic [1:0][31:0] r_data;
    logic [1:0]       r_valid, busy, addr_err;

    always #5 clk = ~clk;

    dp_ram_param #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(INITV[0])) u0 (
        .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(wa), .r_addr(ra),
        .w_data(wd), .w_be(be), .r_data(r_data[0]), .r_valid(r_valid[0]),
        .busy(busy[0]), .addr_err(addr_err[0])
    );

    dp_ram_param #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(INITV[1])) u1 (
        .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(wa), .r_addr(ra),
        .w_data(wd), .w_be(be), .r_data(r_data[1]), .r_valid(r_valid[1]),
        .busy(busy[1]), .addr_err(addr_err[1])
    );

    // Reference model: word array, results scheduled by the edge at which they must appear
    logic [31:0] m       [2][DEPTH];
    logic        sched_v [2][4];
    logic [31:0] sched_d [2][4];
    logic [31:0] exp_data  [2];
    logic        exp_valid [2];
    logic        exp_err   [2];
    int          clr_cnt;
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.busy", i),     32'(busy[i]),     32'(clr_cnt > 0));
            check($sformatf("u%0d.r_valid", i),  32'(r_valid[i]),  32'(exp_valid[i]));
            check($sformatf("u%0d.r_data", i),   r_data[i],        exp_data[i]);
            check($sformatf("u%0d.addr_err", i), 32'(addr_err[i]), 32'(exp_err[i]));
        end
    endtask

    task automatic model_reset();
        clr_cnt = DEPTH;
        for (int i = 0; i < 2; i++) begin
            exp_data[i]  = '0;
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            for (int s = 0; s < 4; s++) sched_v[i][s] = 1'b0;
            for (int a = 0; a < DEPTH; a++) m[i][a] = INITV[i];
        end
    endtask

    task automatic model_edge();
        logic [31:0] mask, rv;
        int slot;
        mask = '0;
        for (int b = 0; b < 4; b++) if (be[b]) mask |= 32'hFF << (8 * b);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            exp_err[i] = 1'b0;
            if (clr_cnt == 0 && enb) begin
                if (rd) begin
                    rv = (ra < DEPTH) ? m[i][ra] : 32'h0;
                    if (RDW[i] == 1 && wr && wa < DEPTH && wa == ra) rv = (rv & ~mask) | (wd & mask);
                    slot = (cyc + LAT[i] - 1) % 4;
                    sched_v[i][slot] = 1'b1;
                    sched_d[i][slot] = rv;
                end
                if (wr && wa < DEPTH) m[i][wa] = (m[i][wa] & ~mask) | (wd & mask);
                exp_err[i] = (wr && wa >= DEPTH) || (rd && ra >= DEPTH);
            end
            slot = cyc % 4;
            exp_valid[i] = sched_v[i][slot];
            if (sched_v[i][slot]) exp_data[i] = sched_d[i][slot];
            sched_v[i][slot] = 1'b0;
        end
        if (clr_cnt > 0) clr_cnt--;
    endtask

    task automatic step(input logic e, input logic w, input logic r, input logic [3:0] a_w,
                        input logic [3:0] a_r, input logic [31:0] d, input logic [3:0] b);
        enb = e; wr = w; rd = r; wa = a_w; ra = a_r; wd = d; be = b;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 4'd0, 4'd0, 32'h0, 4'h0);
    endtask

    // Called at a negedge; asserts reset asynchronously and releases it at a later negedge
    task automatic do_reset(input int hold);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        cyc = 0;
        @(negedge clk);
        do_reset(2);
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) step(1, 0, 1, 4'd0, 4'(a), 32'h0, 4'h0);
        idle(2);
        step(1, 1, 0, 4'd3, 4'd0, 32'hA5, 4'hF);
        step(1, 0, 1, 4'd0, 4'd3, 32'h0, 4'h0);
        idle(2);
        step(1, 1, 0, 4'd5, 4'd0, 32'h1122_3344, 4'hF);
        step(1, 1, 0, 4'd5, 4'd0, 32'hAABB_CCDD, 4'b0101);
        step(1, 0, 1, 4'd0, 4'd5, 32'h0, 4'h0);
        idle(2);
        step(1, 1, 0, 4'd7, 4'd0, 32'h10, 4'hF);
        step(1, 1, 1, 4'd7, 4'd7, 32'h77, 4'hF);
        step(1, 0, 1, 4'd0, 4'd7, 32'h0, 4'h0);
        idle(2);
        step(1, 1, 0, 4'd13, 4'd0, 32'hFFFF_FFFF, 4'hF);
        step(1, 0, 1, 4'd0, 4'd13, 32'h0, 4'h0);
        step(1, 1, 1, 4'd14, 4'd15, 32'h1234_5678, 4'hF);
        step(1, 1, 1, 4'd2, 4'd11, 32'hCAFE_F00D, 4'hF);
        step(0, 1, 1, 4'd4, 4'd2, 32'h5555_5555, 4'hF);
        step(1, 0, 1, 4'd0, 4'd2, 32'h0, 4'h0);
        idle(2);
        step(1, 0, 1, 4'd0, 4'd3, 32'h0, 4'h0);
        do_reset(1);
        idle(9);
        do_reset(1);
        idle(DEPTH + 1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) begin
                do_reset($urandom_range(3, 1));
            end else begin
                step($urandom_range(9) < 8, $urandom_range(1) == 1, $urandom_range(1) == 1,
                     4'($urandom_range(15)), 4'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
            end
        end
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
